// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared constants and entry type for the fetch-to-decode instruction queue.
// Contents:
//   N        - PC width in bits
//   IW       - instruction width in bits
//   FQ_DEPTH - default queue depth (power of two, >= 2)
//   fq_entry_t - one stored {pc, instr} pair
package fetch_pkg;

  localparam int N        = 64;
  localparam int IW       = 32;
  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [IW-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem
// Entry storage for fetch_queue: DEPTH x fq_entry_t register array with one
// synchronous write port and one asynchronous read port. Contents are never
// reset; the owning queue only reads slots it has written.
// Ports:
//   clk   in  - clock, write on rising edge
//   we    in  - write enable
//   waddr in  - write slot index
//   wdata in  - entry to store
//   raddr in  - read slot index
//   rdata out - entry at raddr (combinational)
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdata
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// In-order instruction queue between fetch and decode. Captures {PC, instr}
// pairs from fetch, presents the oldest to decode with valid/ready, stalls
// fetch when full and drops everything on a taken-branch flush.
// N and IW must match the fetch_pkg constants, since storage uses fq_entry_t.
// Optional feature: FETCH_QUEUE_BYPASS_EN - when the queue is empty, an
// incoming entry is passed straight to decode in the same cycle and is only
// stored if decode does not take it.
// Ports:
//   clk         in  - clock
//   reset       in  - synchronous active-high reset
//   imem_addr_F in  - PC of the instruction being pushed
//   instr_F     in  - instruction word at imem_addr_F
//   valid_F     in  - fetch presents an entry
//   stall_F     out - queue full, fetch must hold
//   flush       in  - taken branch, drop all entries
//   pc_D        out - PC of head entry (0 when empty)
//   instr_D     out - instruction of head entry (0 when empty)
//   valid_D     out - head entry valid
//   ready_D     in  - decode accepts head entry
//   count       out - number of stored entries
module fetch_queue #(
  parameter int N     = fetch_pkg::N,
  parameter int IW    = fetch_pkg::IW,
  parameter int DEPTH = fetch_pkg::FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               imem_addr_F,
  input  logic [IW-1:0]              instr_F,
  input  logic                       valid_F,
  output logic                       stall_F,
  input  logic                       flush,
  output logic [N-1:0]               pc_D,
  output logic [IW-1:0]              instr_D,
  output logic                       valid_D,
  input  logic                       ready_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  import fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  logic      q_valid;
  logic      push;
  logic      pop;
  fq_entry_t wdata;
  fq_entry_t rdata;

  assign stall_F = (count_q == CW'(DEPTH));
  assign q_valid = (count_q != '0);
  assign count   = count_q;

  assign wdata.pc    = imem_addr_F;
  assign wdata.instr = instr_F;

  // pop only depends on the stored head; in bypass mode an empty queue never
  // pops, the pass-through entry is handled by suppressing the push instead.
  assign pop = q_valid & ready_D & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp_act;

  assign byp_act = ~q_valid & valid_F & ~flush;
  assign push    = valid_F & ~stall_F & ~flush & ~(byp_act & ready_D);
  assign valid_D = q_valid | byp_act;
  assign pc_D    = byp_act ? imem_addr_F : (q_valid ? rdata.pc    : '0);
  assign instr_D = byp_act ? instr_F     : (q_valid ? rdata.instr : '0);
`else
  assign push    = valid_F & ~stall_F & ~flush;
  assign valid_D = q_valid;
  assign pc_D    = q_valid ? rdata.pc    : '0;
  assign instr_D = q_valid ? rdata.instr : '0;
`endif

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Writes during reset are harmless: pointers restart at 0 and count is 0.
  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_q),
    .wdata (wdata),
    .raddr (rd_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int N     = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [N-1:0]  imem_addr_F;
  logic [IW-1:0] instr_F;
  logic          valid_F;
  logic          stall_F;
  logic          flush;
  logic [N-1:0]  pc_D;
  logic [IW-1:0] instr_D;
  logic          valid_D;
  logic          ready_D;
  logic [CW-1:0] count;

  fetch_queue #(.N(N), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr_F (imem_addr_F),
    .instr_F     (instr_F),
    .valid_F     (valid_F),
    .stall_F     (stall_F),
    .flush       (flush),
    .pc_D        (pc_D),
    .instr_D     (instr_D),
    .valid_D     (valid_D),
    .ready_D     (ready_D),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t q[$];
  bit   known;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected outputs follow from the reference queue contents and current
  // inputs; queue state changes at the next rising edge.
  task automatic step(input logic v, input logic [N-1:0] pc, input logic [IW-1:0] ins,
                      input logic rdy, input logic fl, input logic rs);
    int   sz;
    logic e_valid;
    logic [N-1:0]  e_pc;
    logic [IW-1:0] e_instr;
    bit   consumed, do_push, do_pop;
    valid_F     = v;
    imem_addr_F = pc;
    instr_F     = ins;
    ready_D     = rdy;
    flush       = fl;
    reset       = rs;
    #1;
    sz = q.size();
    e_valid = (sz != 0);
    e_pc    = (sz != 0) ? q[0].pc    : '0;
    e_instr = (sz != 0) ? q[0].instr : '0;
    if (BYP && sz == 0 && v && !fl) begin
      e_valid = 1'b1;
      e_pc    = pc;
      e_instr = ins;
    end
    if (known) begin
      chk("count",   64'(count),   64'(sz));
      chk("stall_F", 64'(stall_F), 64'(sz == DEPTH));
      chk("valid_D", 64'(valid_D), 64'(e_valid));
      chk("pc_D",    64'(pc_D),    64'(e_pc));
      chk("instr_D", 64'(instr_D), 64'(e_instr));
    end
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else begin
      consumed = BYP && sz == 0 && v && rdy;
      do_push  = v && (sz < DEPTH) && !consumed;
      do_pop   = (sz != 0) && rdy;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{pc: pc, instr: ins});
    end
    if (rs) known = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic push_pc(input logic [N-1:0] pc, input logic rdy);
    step(1'b1, pc, 32'h8B1F03E0 + pc[IW-1:0], rdy, 1'b0, 1'b0);
  endtask

  initial begin
    known = 1'b0; n_chk = 0; n_pass = 0;
    valid_F = 0; imem_addr_F = '0; instr_F = '0; ready_D = 0; flush = 0; reset = 1;

    // reset 3 cycles
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // fill to full, fifth push ignored
    for (int i = 0; i < 4; i++) push_pc(64'(4*i), 1'b0);
    push_pc(64'd16, 1'b0);
    idle(1'b0);

    // drain
    for (int i = 0; i < 5; i++) idle(1'b1);

    // full with simultaneous pop and push: push must be refused
    for (int i = 0; i < 4; i++) push_pc(64'h200 + 64'(4*i), 1'b0);
    push_pc(64'h300, 1'b1);
    push_pc(64'h304, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // streaming with wrap
    for (int i = 0; i < 10; i++) push_pc(64'h100 + 64'(4*i), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush with concurrent push, then new head
    for (int i = 0; i < 3; i++) push_pc(64'h80 + 64'(4*i), 1'b0);
    step(1'b1, 64'h40, 32'h8B1F0420, 1'b1, 1'b1, 1'b0);
    push_pc(64'h1000, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // reset mid-stream
    push_pc(64'h500, 1'b0);
    push_pc(64'h504, 1'b0);
    step(1'b1, 64'h508, 32'h1, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    push_pc(64'h600, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // bypass-style empty push with ready (checked against model in either build)
    push_pc(64'h20, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, r, f, rs;
      logic [N-1:0] pc;
      v  = ($urandom_range(0, 99) < 70);
      r  = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 4);
      rs = ($urandom_range(0, 199) < 2);
      pc = {$urandom, $urandom};
      step(v, pc, $urandom, r, f, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
